// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-flight branch prediction FIFO that resolves branches, updates the predictor and redirects on mispredicts
module branch_resolve_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        enq_valid,
  input  logic [31:0] enq_pc,
  input  logic        enq_pred_taken,
  input  logic [31:0] enq_pred_target,
  input  logic        enq_is_rv32c,
  output logic        enq_ready,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        flush,
  output logic        mispredict,
  output logic [31:0] redirect_addr,
  output logic        update_predictor,
  output logic [31:0] pc_to_update,
  output logic [31:0] update_addr,
  output logic        branch_result,
  output logic        underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] pc_q [DEPTH];
  logic [31:0] tg_q [DEPTH];
  logic [DEPTH-1:0] tk_q, c_q;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic do_enq, do_pop, mis;
  logic [31:0] fall;
  assign enq_ready = count < CW'(DEPTH);
  assign do_enq = enq_valid & enq_ready;
  assign do_pop = res_valid & (count != '0);
  assign mis = (tk_q[head] != res_taken) | (res_taken & tk_q[head] & (tg_q[head] != res_target));
  assign fall = pc_q[head] + (c_q[head] ? 32'd2 : 32'd4);
  // entry storage: written at the tail on every accepted enqueue
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        tg_q[i] <= '0;
      end
      tk_q <= '0;
      c_q  <= '0;
    end else if (do_enq && !flush) begin
      pc_q[tail] <= enq_pc;
      tg_q[tail] <= enq_pred_target;
      tk_q[tail] <= enq_pred_taken;
      c_q[tail]  <= enq_is_rv32c;
    end
  end
  // pointers, occupancy and registered resolution outputs; flush wins, a mispredict empties the queue
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      mispredict       <= 1'b0;
      update_predictor <= 1'b0;
      underflow        <= 1'b0;
      redirect_addr    <= '0;
      pc_to_update     <= '0;
      update_addr      <= '0;
      branch_result    <= 1'b0;
    end else if (flush) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      mispredict       <= 1'b0;
      update_predictor <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      update_predictor <= do_pop;
      mispredict       <= do_pop & mis;
      underflow        <= res_valid & (count == '0);
      if (do_pop) begin
        pc_to_update  <= pc_q[head];
        update_addr   <= res_taken ? res_target : tg_q[head];
        branch_result <= res_taken;
        if (mis) redirect_addr <= res_taken ? res_target : fall;
      end
      if (do_pop && mis) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (do_enq) tail <= tail + AW'(1);
        if (do_pop) head <= head + AW'(1);
        count <= count + CW'(do_enq) - CW'(do_pop);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed and random checks of branch_resolve_queue against a queue-based model
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        enq_valid = 0, enq_pred_taken = 0, enq_is_rv32c = 0, res_valid = 0, res_taken = 0, flush = 0;
  logic [31:0] enq_pc = 0, enq_pred_target = 0, res_target = 0;
  logic        enq_ready, mispredict, update_predictor, branch_result, underflow;
  logic [31:0] redirect_addr, pc_to_update, update_addr;
  int n_chk = 0, n_fail = 0;

  typedef struct {logic [31:0] pc; logic tk; logic [31:0] tg; logic c;} ent_t;
  ent_t q[$];
  logic        e_upd = 0, e_mp = 0, e_uf = 0, e_br = 0;
  logic [31:0] e_ra = 0, e_pc = 0, e_ua = 0;

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
    .enq_pred_target(enq_pred_target), .enq_is_rv32c(enq_is_rv32c), .enq_ready(enq_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target), .flush(flush),
    .mispredict(mispredict), .redirect_addr(redirect_addr), .update_predictor(update_predictor),
    .pc_to_update(pc_to_update), .update_addr(update_addr), .branch_result(branch_result),
    .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ":update_predictor"}, 32'(update_predictor), 32'(e_upd));
    chk({tag, ":mispredict"}, 32'(mispredict), 32'(e_mp));
    chk({tag, ":underflow"}, 32'(underflow), 32'(e_uf));
    chk({tag, ":redirect_addr"}, redirect_addr, e_ra);
    chk({tag, ":pc_to_update"}, pc_to_update, e_pc);
    chk({tag, ":update_addr"}, update_addr, e_ua);
    chk({tag, ":branch_result"}, 32'(branch_result), 32'(e_br));
    chk({tag, ":enq_ready"}, 32'(enq_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic step(input string tag, input logic ev, input logic [31:0] pc, input logic pt,
                      input logic [31:0] tg, input logic c, input logic rv, input logic rt,
                      input logic [31:0] rtg, input logic fl);
    ent_t h;
    logic rdy, mis;
    enq_valid = ev; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = tg; enq_is_rv32c = c;
    res_valid = rv; res_taken = rt; res_target = rtg; flush = fl;
    e_upd = 0; e_mp = 0; e_uf = 0; mis = 0;
    if (fl) q.delete();
    else begin
      rdy = q.size() < DEPTH;
      if (rv && q.size() == 0) e_uf = 1;
      if (rv && q.size() > 0) begin
        h = q.pop_front();
        mis = (h.tk != rt) || (h.tk && rt && h.tg != rtg);
        e_upd = 1; e_pc = h.pc; e_ua = rt ? rtg : h.tg; e_br = rt;
        if (mis) begin
          e_mp = 1;
          e_ra = rt ? rtg : h.pc + (h.c ? 32'd2 : 32'd4);
        end
      end
      if (mis) q.delete();
      else if (ev && rdy) q.push_back('{pc, pt, tg, c});
    end
    @(posedge CLK);
    #1;
    chk_all(tag);
  endtask

  task automatic enq(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] tg, input logic c);
    step(tag, 1, pc, pt, tg, c, 0, 0, 0, 0);
  endtask

  task automatic res(input string tag, input logic rt, input logic [31:0] rtg);
    step(tag, 0, 0, 0, 0, 0, 1, rt, rtg, 0);
  endtask

  task automatic reset_model();
    q.delete();
    e_upd = 0; e_mp = 0; e_uf = 0; e_br = 0; e_ra = 0; e_pc = 0; e_ua = 0;
  endtask

  initial begin
    logic [31:0] tgs [4];
    tgs[0] = 32'h1000; tgs[1] = 32'h2000; tgs[2] = 32'hFFFF_FFFE; tgs[3] = 32'h0;
    reset_model();
    #12;
    chk_all("reset");
    nRST = 1;
    @(posedge CLK); #1;
    enq("r20_enq", 32'h100, 0, 32'h0, 0);
    res("r20_res", 0, 32'h0);
    step("r20_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    enq("r21_enq", 32'h200, 1, 32'h400, 0);
    res("r21_res", 1, 32'h480);
    res("r21_empty", 0, 0);
    enq("r22_e0", 32'h300, 1, 32'h500, 1);
    enq("r22_e1", 32'h304, 0, 32'h0, 0);
    enq("r22_e2", 32'h308, 0, 32'h0, 0);
    res("r22_res", 0, 32'h0);
    res("r22_empty", 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) enq("r23_fill", 32'h1000 + 32'(i * 4), 0, 0, 0);
    for (int i = 0; i < 3 * DEPTH; i++)
      step("r23_wrap", 1, 32'h2000 + 32'(i * 4), 0, 0, i[0], 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) res("r23_drain", 0, 0);
    res("r24_uf", 1, 32'h40);
    step("r24_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) enq("r25_fill", 32'h600 + 32'(i * 4), 1, 32'h700, 0);
    step("r25_flush", 1, 32'h6F0, 0, 0, 0, 1, 0, 0, 1);
    res("r25_empty", 1, 32'h700);
    enq("rst_e0", 32'h800, 1, 32'h900, 0);
    enq("rst_e1", 32'h804, 0, 32'h0, 1);
    res("rst_res", 0, 0);
    enq("rst_e2", 32'h808, 0, 32'h0, 0);
    nRST = 0;
    #1;
    reset_model();
    chk_all("rst_async");
    @(posedge CLK); #1;
    nRST = 1;
    step("rst_first", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    res("rst_empty", 0, 0);
    step("wrap_pc", 1, 32'hFFFF_FFFE, 1, 32'h10, 1, 0, 0, 0, 0);
    res("wrap_res", 0, 0);
    for (int i = 0; i < 500; i++)
      step("rand", ($urandom % 3) != 0, $urandom & 32'hFFFF_FFFE, 1'($urandom), tgs[$urandom % 4],
           1'($urandom), 1'($urandom), 1'($urandom), tgs[$urandom % 4], ($urandom % 25) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of in-flight predicted branches tracked; legal values are powers of two, 2 or more.
REQ-002 The module SHALL use one clock and an asynchronous, active-low reset, with ports named CLK and nRST.
REQ-003 The module SHALL have these ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- enq_valid  in  1  fetch records one branch prediction
- enq_pc  in  32  PC of the predicted instruction
- enq_pred_taken  in  1  predicted direction
- enq_pred_target  in  32  predicted target
- enq_is_rv32c  in  1  instruction is compressed
- enq_ready  out  1  queue can accept an entry
- res_valid  in  1  execute resolves the oldest branch
- res_taken  in  1  actual direction
- res_target  in  32  actual target
- flush  in  1  external pipeline flush
- mispredict  out  1  one-cycle redirect pulse
- redirect_addr  out  32  correct next PC
- update_predictor  out  1  one-cycle predictor update strobe
- pc_to_update  out  32  PC written to predictor
- update_addr  out  32  target written to predictor
- branch_result  out  1  actual direction written to predictor
- underflow  out  1  one-cycle pulse when a resolution arrives while empty

Function
REQ-004 The queue SHALL be a circular FIFO of DEPTH entries {pc, pred_taken, pred_target, is_rv32c}, with head pointer, tail pointer and count; count width is clog2(DEPTH+1).
REQ-005 enq_ready SHALL equal (count < DEPTH), combinationally, with no same-cycle pop bypass.
REQ-006 An enqueue SHALL occur when enq_valid and enq_ready are both high; the entry is written at the tail and the tail wraps modulo DEPTH.
REQ-007 When enq_valid is high and enq_ready is low, the input SHALL be ignored and the state SHALL be unchanged.
REQ-008 A pop SHALL occur when res_valid is high and count > 0; the pop uses the head entry as it was before any same-cycle enqueue.
REQ-009 A resolution SHALL be mispredicted if pred_taken != res_taken, or if both are taken and pred_target != res_target.
REQ-010 Fallthrough SHALL equal pc+2 when is_rv32c is set and pc+4 otherwise, with 32-bit wrap-around and no carry out.
REQ-011 On a pop, the cycle after SHALL carry registered outputs for exactly one cycle:
- update_predictor = 1
- pc_to_update = head pc
- update_addr = res_taken ? res_target : head pred_target
- branch_result = res_taken
REQ-012 On a mispredicted pop, the cycle after SHALL carry mispredict = 1 and redirect_addr = res_taken ? res_target : fallthrough; all other entries and any same-cycle enqueue SHALL be discarded, leaving count = 0 and head = tail.
REQ-013 On a correctly predicted pop, mispredict SHALL stay 0 and redirect_addr SHALL hold its previous value.
REQ-014 A simultaneous enqueue and pop with no mispredict SHALL leave count unchanged, with both pointers advancing.
REQ-015 res_valid with count = 0 SHALL produce no update and no mispredict, and SHALL pulse underflow in the next cycle; a same-cycle enqueue still proceeds.
REQ-016 flush SHALL have priority over every other input: the next state has count = 0 and head = tail = 0; the same-cycle enqueue and resolution are dropped; update_predictor, mispredict and underflow are 0 in the next cycle.
REQ-017 Outputs that are not strobed SHALL hold their last value; only the strobes return to 0.

Reset
REQ-018 While nRST is low, all of the following SHALL be cleared asynchronously: head, tail, count, all entries, mispredict, update_predictor, underflow, redirect_addr, pc_to_update, update_addr and branch_result; enq_ready then reads 1.
REQ-019 A reset asserted mid-operation SHALL discard every in-flight entry, and no strobe SHALL fire in the first cycle after reset is released.

Verification
REQ-020 The bench SHALL cover: enqueue {pc=0x100, not-taken, is_rv32c=0}, then resolve not-taken -> next cycle update_predictor=1, pc_to_update=0x100, branch_result=0, mispredict=0.
REQ-021 The bench SHALL cover: enqueue {0x200, taken, target=0x400}, then resolve taken with target 0x480 -> mispredict=1, redirect_addr=0x480, update_addr=0x480, count=0.
REQ-022 The bench SHALL cover: enqueue {0x300, taken, target 0x500, is_rv32c=1} and two younger entries, then resolve not-taken -> redirect_addr=0x302, all entries flushed, enq_ready=1.
REQ-023 The bench SHALL cover: filling DEPTH entries -> enq_ready=0 and a further enqueue is dropped; then a simultaneous pop and enqueue over more than 2×DEPTH cycles -> FIFO order preserved across pointer wrap.
REQ-024 The bench SHALL cover: res_valid while empty -> underflow=1 for one cycle, update_predictor=0.
REQ-025 The bench SHALL cover: flush asserted together with res_valid and enq_valid while 3 entries are queued -> next cycle count=0, with no update and no mispredict.
